// File: rtl/fp_unpack_pipe_pkg.sv
// Shared FPU front-end widths and operand record types.
package fpu_pkg;
    localparam int EW  = 11;
    localparam int FW  = 52;
    localparam int SEW = 8;
    localparam int SFW = 23;
    localparam int W   = 1 + EW + FW;
    localparam int LZW = $clog2(FW + 2);

    typedef struct packed {
        logic           s;
        logic [EW-1:0]  e;
        logic           e_inf;
        logic           e_z;
        logic [FW:0]    f;
        logic [FW-1:0]  h;
        logic           fz;
        logic [LZW-1:0] lz;
    } unpacked_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_snan;
    } fp_class_t;
endpackage

// File: rtl/fp_unpack_pipe_if.sv
// Operand bus into the unpacker and unpacked result bus out of it.
interface fp_unpack_pipe_if #(parameter int TAGW = 4);
    import fpu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      fp;
    logic              db;
    logic              normal;
    logic [TAGW-1:0]   tag_in;
    logic              out_valid;
    logic              out_ready;
    logic              s;
    logic [EW-1:0]     e;
    logic              e_inf;
    logic              e_z;
    logic [FW:0]       f;
    logic [FW-1:0]     h;
    logic              fz;
    logic [LZW-1:0]    lz;
    logic              is_zero;
    logic              is_inf;
    logic              is_nan;
    logic              is_snan;
    logic [TAGW-1:0]   tag_out;

    modport slave (
        input  in_valid, fp, db, normal, tag_in, out_ready,
        output in_ready, out_valid, s, e, e_inf, e_z, f, h, fz, lz,
               is_zero, is_inf, is_nan, is_snan, tag_out
    );

    modport master (
        output in_valid, fp, db, normal, tag_in, out_ready,
        input  in_ready, out_valid, s, e, e_inf, e_z, f, h, fz, lz,
               is_zero, is_inf, is_nan, is_snan, tag_out
    );
endinterface

// File: rtl/fp_unpack_pipe_lzc_shift.sv
// Leading-zero count of one significand and left shift of another, so the
// count can sit in stage 1 while the shift sits in stage 2.
module lzc_shift #(
    parameter int N  = 53,
    parameter int LW = $clog2(N + 1)
) (
    input  logic [N-1:0]  cnt_d_i,
    output logic [LW-1:0] lz_o,
    input  logic [N-1:0]  shf_d_i,
    input  logic [LW-1:0] shf_amt_i,
    output logic [N-1:0]  shf_q_o
);
    // Scanning upward lets the highest set bit win; all-zero leaves N.
    always_comb begin
        lz_o = LW'(N);
        for (int i = 0; i < N; i++) begin
            if (cnt_d_i[i]) lz_o = LW'(N - 1 - i);
        end
    end

    assign shf_q_o = shf_d_i << shf_amt_i;
endmodule

// File: rtl/fp_unpack_pipe.sv
// Two-stage valid/ready operand unpacker: stage 1 extracts fields, classifies
// and counts leading zeros; stage 2 applies the optional normalising shift.
module fp_unpack_pipe
    import fpu_pkg::*;
#(
    parameter int TAGW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    fp_unpack_pipe_if.slave    bus
);
    logic            v1_q, v1_d, v2_q, v2_d;
    logic            adv2, ld1;
    logic [EW-1:0]   exp_w;
    logic [SEW-1:0]  exp_n;
    logic [SFW-1:0]  frac_n;
    logic [EW-1:0]   e_in;
    logic            e_inf_in, e_z_in, fz_in;
    logic [FW-1:0]   h_in;
    logic [FW:0]     fu_in, f_shf;
    logic [LZW-1:0]  lz_in;
    unpacked_t       u_in, u1_q, u2_q, u2_d;
    fp_class_t       c_in, c1_q, c2_q;
    logic            n1_q;
    logic [TAGW-1:0] t1_q, t2_q;

    assign exp_w  = bus.fp[W-2 -: EW];
    assign exp_n  = bus.fp[W-2 -: SEW];
    assign frac_n = bus.fp[W-2-SEW -: SFW];

    always_comb begin
        if (bus.db) begin
            e_in     = exp_w;
            e_inf_in = &exp_w;
            e_z_in   = ~|exp_w;
            h_in     = bus.fp[FW-1:0];
        end else begin
            e_in     = EW'(exp_n);
            e_inf_in = &exp_n;
            e_z_in   = ~|exp_n;
            h_in     = {frac_n, {(FW-SFW){1'b0}}};
        end
    end

    assign fz_in = ~|h_in;
    assign fu_in = {~e_z_in, h_in};

    lzc_shift #(.N(FW + 1), .LW(LZW)) u_lzc (
        .cnt_d_i   (fu_in),
        .lz_o      (lz_in),
        .shf_d_i   (u1_q.f),
        .shf_amt_i (u1_q.lz),
        .shf_q_o   (f_shf)
    );

    assign u_in = '{s: bus.fp[W-1], e: e_in, e_inf: e_inf_in, e_z: e_z_in,
                    f: fu_in, h: h_in, fz: fz_in, lz: lz_in};

    assign c_in.is_zero = e_z_in & fz_in;
    assign c_in.is_inf  = e_inf_in & fz_in;
    assign c_in.is_nan  = e_inf_in & ~fz_in;
    assign c_in.is_snan = e_inf_in & ~fz_in & ~h_in[FW-1];

    // An all-zero significand gets a shift of FW+1, which already yields zero.
    always_comb begin
        u2_d   = u1_q;
        u2_d.f = n1_q ? f_shf : u1_q.f;
    end

    always_comb begin
        adv2 = ~v2_q | bus.out_ready;
        ld1  = ~v1_q | adv2;
        v1_d = flush ? 1'b0 : (ld1 ? bus.in_valid : v1_q);
        v2_d = flush ? 1'b0 : (adv2 ? v1_q : v2_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            u1_q <= '0;
            c1_q <= '0;
            n1_q <= 1'b0;
            t1_q <= '0;
        end else begin
            v1_q <= v1_d;
            if (ld1 & bus.in_valid) begin
                u1_q <= u_in;
                c1_q <= c_in;
                n1_q <= bus.normal;
                t1_q <= bus.tag_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
            u2_q <= '0;
            c2_q <= '0;
            t2_q <= '0;
        end else begin
            v2_q <= v2_d;
            if (adv2 & v1_q) begin
                u2_q <= u2_d;
                c2_q <= c1_q;
                t2_q <= t1_q;
            end
        end
    end

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v2_q;
    assign bus.s         = u2_q.s;
    assign bus.e         = u2_q.e;
    assign bus.e_inf     = u2_q.e_inf;
    assign bus.e_z       = u2_q.e_z;
    assign bus.f         = u2_q.f;
    assign bus.h         = u2_q.h;
    assign bus.fz        = u2_q.fz;
    assign bus.lz        = u2_q.lz;
    assign bus.is_zero   = c2_q.is_zero;
    assign bus.is_inf    = c2_q.is_inf;
    assign bus.is_nan    = c2_q.is_nan;
    assign bus.is_snan   = c2_q.is_snan;
    assign bus.tag_out   = t2_q;
endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Randomised and directed bench for fp_unpack_pipe against an arithmetic
// model of the unpacking rules, with a queue as the in-flight scoreboard.
module tb_fp_unpack_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    fp_unpack_pipe_if #(.TAGW(4)) bus ();

    fp_unpack_pipe #(.TAGW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [10:0] e;
        logic        e_inf;
        logic        e_z;
        logic [52:0] f;
        logic [51:0] h;
        logic        fz;
        logic [5:0]  lz;
        logic        zero, inf, nan, snan;
        logic [3:0]  tag;
    } exp_t;

    exp_t         sb[$];
    logic [3:0]   out_tags[$];
    int           n_vec = 0;
    int           n_err = 0;

    logic [63:0]  cur_fp;
    logic         cur_db, cur_nm, cur_flush, cur_acc_in, cur_acc_out;
    logic [3:0]   cur_tag;
    logic         stalled_prev = 1'b0;
    logic [159:0] prev_snap = '0;

    task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [63:0] fpv, input logic dbv,
                                   input logic nv, input logic [3:0] tg);
        exp_t r;
        longint unsigned ex, hh, fu, x;
        int lz;
        logic einf, ez;
        if (dbv) begin
            ex   = (fpv >> 52) & 64'h7FF;
            hh   = fpv & 64'h000F_FFFF_FFFF_FFFF;
            einf = (ex == 2047);
        end else begin
            ex   = (fpv >> 55) & 64'hFF;
            hh   = ((fpv >> 32) & 64'h7F_FFFF) << 29;
            einf = (ex == 255);
        end
        ez = (ex == 0);
        fu = hh + (ez ? 64'd0 : (64'd1 << 52));
        if (fu == 0) lz = 53;
        else begin
            lz = 0;
            x  = fu;
            while (x < (64'd1 << 52)) begin
                x = x * 2;
                lz++;
            end
        end
        r.s     = fpv[63];
        r.e     = ex[10:0];
        r.e_inf = einf;
        r.e_z   = ez;
        r.h     = hh[51:0];
        r.fz    = (hh == 0);
        r.lz    = lz[5:0];
        x       = (fu == 0) ? 64'd0 : (nv ? (fu << lz) : fu);
        r.f     = x[52:0];
        r.zero  = ez && (hh == 0);
        r.inf   = einf && (hh == 0);
        r.nan   = einf && (hh != 0);
        r.snan  = einf && (hh != 0) && (hh < (64'd1 << 51));
        r.tag   = tg;
        return r;
    endfunction

    function automatic logic [159:0] snap();
        return 160'({bus.s, bus.e, bus.e_inf, bus.e_z, bus.f, bus.h, bus.fz, bus.lz,
                     bus.is_zero, bus.is_inf, bus.is_nan, bus.is_snan, bus.tag_out});
    endfunction

    function automatic logic [63:0] rand_fp(input logic dbv);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: if (dbv) v[62:52] = '0; else v[62:55] = '0;
            1: if (dbv) v[62:52] = '1; else v[62:55] = '1;
            2: if (dbv) v[51:0] = '0; else v[54:32] = '0;
            3: v[62:0] = 63'(1) << $urandom_range(0, 62);
            4: if (dbv) v[62:0] = '0; else v[62:32] = '0;
            default: ;
        endcase
        return v;
    endfunction

    task automatic drive_chk(input logic vin, input logic [63:0] fpv, input logic dbv,
                             input logic nv, input logic [3:0] tg, input logic ordy,
                             input logic fl);
        @(negedge clk);
        bus.in_valid  = vin;
        bus.fp        = fpv;
        bus.db        = dbv;
        bus.normal    = nv;
        bus.tag_in    = tg;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        chk("in_ready", bus.in_ready, (sb.size() < 2) || ordy);
        if (stalled_prev) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", snap(), prev_snap);
        end
        if (bus.out_valid) begin
            if (sb.size() == 0) chk("spurious_out", bus.out_valid, 0);
            else begin
                chk("s", bus.s, sb[0].s);
                chk("e", bus.e, sb[0].e);
                chk("e_inf", bus.e_inf, sb[0].e_inf);
                chk("e_z", bus.e_z, sb[0].e_z);
                chk("f", bus.f, sb[0].f);
                chk("h", bus.h, sb[0].h);
                chk("fz", bus.fz, sb[0].fz);
                chk("lz", bus.lz, sb[0].lz);
                chk("is_zero", bus.is_zero, sb[0].zero);
                chk("is_inf", bus.is_inf, sb[0].inf);
                chk("is_nan", bus.is_nan, sb[0].nan);
                chk("is_snan", bus.is_snan, sb[0].snan);
                chk("tag_out", bus.tag_out, sb[0].tag);
            end
        end
        cur_fp      = fpv;
        cur_db      = dbv;
        cur_nm      = nv;
        cur_tag     = tg;
        cur_flush   = fl;
        cur_acc_in  = vin & bus.in_ready & ~fl;
        cur_acc_out = bus.out_valid & ordy;
        if (cur_acc_out) out_tags.push_back(bus.tag_out);
        stalled_prev = bus.out_valid & ~ordy & ~fl;
        prev_snap    = snap();
    endtask

    task automatic commit();
        @(posedge clk);
        if (cur_acc_out && sb.size() > 0) void'(sb.pop_front());
        if (cur_flush) sb.delete();
        else if (cur_acc_in) sb.push_back(model(cur_fp, cur_db, cur_nm, cur_tag));
    endtask

    task automatic idle(input logic ordy);
        drive_chk(1'b0, 64'h0, 1'b1, 1'b0, 4'h0, ordy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            idle(1'b1);
            commit();
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic dir_op(input string nm, input logic [63:0] fpv, input logic dbv,
                          input logic nv, input logic s_x, input logic [10:0] e_x,
                          input logic [52:0] f_x, input logic [51:0] h_x,
                          input logic [5:0] lz_x, input logic [3:0] cls_x);
        drain();
        drive_chk(1'b1, fpv, dbv, nv, 4'h5, 1'b1, 1'b0);
        commit();
        idle(1'b1);
        chk({nm, "_lat1"}, bus.out_valid, 0);
        commit();
        idle(1'b1);
        chk({nm, "_lat2"}, bus.out_valid, 1);
        chk({nm, "_s"}, bus.s, s_x);
        chk({nm, "_e"}, bus.e, e_x);
        chk({nm, "_f"}, bus.f, f_x);
        chk({nm, "_h"}, bus.h, h_x);
        chk({nm, "_lz"}, bus.lz, lz_x);
        chk({nm, "_cls"}, {bus.is_zero, bus.is_inf, bus.is_nan, bus.is_snan}, cls_x);
        commit();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int idx, leaks;
        logic dbv, seen_stall;
        bus.in_valid  = 1'b0;
        bus.fp        = '0;
        bus.db        = 1'b1;
        bus.normal    = 1'b0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_outputs", snap(), 0);
        @(negedge clk);
        rst = 1'b0;

        dir_op("one", 64'h3FF0_0000_0000_0000, 1'b1, 1'b0, 1'b0, 11'h3FF,
               53'd1 << 52, 52'd0, 6'd0, 4'b0000);
        dir_op("sden_n", 64'h0000_0001_0000_0000, 1'b0, 1'b1, 1'b0, 11'h0,
               53'd1 << 52, 52'd1 << 29, 6'd23, 4'b0000);
        dir_op("sden_u", 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 11'h0,
               53'd1 << 29, 52'd1 << 29, 6'd23, 4'b0000);
        dir_op("snan", 64'h7FF0_0000_0000_0001, 1'b1, 1'b0, 1'b0, 11'h7FF,
               (53'd1 << 52) | 53'd1, 52'd1, 6'd0, 4'b0011);
        dir_op("qnan", 64'h7FF8_0000_0000_0000, 1'b1, 1'b0, 1'b0, 11'h7FF,
               (53'd1 << 52) | (53'd1 << 51), 52'd1 << 51, 6'd0, 4'b0010);
        dir_op("negz", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b1, 11'h0,
               53'd0, 52'd0, 6'd53, 4'b1000);
        dir_op("sinf", 64'h7F80_0000_DEAD_BEEF, 1'b0, 1'b1, 1'b0, 11'h0FF,
               53'd1 << 52, 52'd0, 6'd0, 4'b0100);

        // Backpressure: four tagged operands, consumer stalls for cycles 3..6.
        drain();
        out_tags.delete();
        idx = 0;
        seen_stall = 1'b0;
        for (int c = 0; c < 16; c++) begin
            drive_chk(idx < 4, rand_fp(1'b1), 1'b1, 1'b1, idx[3:0], !(c >= 3 && c <= 6), 1'b0);
            if (idx < 4 && !bus.in_ready) seen_stall = 1'b1;
            if (cur_acc_in) idx++;
            commit();
        end
        drain();
        chk("bp_stall_seen", seen_stall, 1);
        chk("bp_count", out_tags.size(), 4);
        for (int i = 0; i < 4 && i < out_tags.size(); i++) chk("bp_order", out_tags[i], i);

        // Flush with both stages full and a new operand offered.
        out_tags.delete();
        drive_chk(1'b1, rand_fp(1'b0), 1'b0, 1'b0, 4'hA, 1'b0, 1'b0);
        commit();
        drive_chk(1'b1, rand_fp(1'b1), 1'b1, 1'b1, 4'hB, 1'b0, 1'b0);
        commit();
        drive_chk(1'b1, rand_fp(1'b1), 1'b1, 1'b0, 4'hC, 1'b0, 1'b1);
        commit();
        idle(1'b1);
        chk("flush_out_valid", bus.out_valid, 0);
        commit();
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            commit();
        end
        leaks = 0;
        foreach (out_tags[i]) if (out_tags[i] inside {4'hA, 4'hB, 4'hC}) leaks++;
        chk("flush_leak", leaks, 0);

        // Randomised traffic with stalls, mode changes and occasional flushes.
        for (int c = 0; c < 500; c++) begin
            dbv = 1'($urandom_range(0, 1));
            drive_chk($urandom_range(0, 9) < 7, rand_fp(dbv), dbv, 1'($urandom_range(0, 1)),
                      4'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
            commit();
        end
        drain();

        // Asynchronous reset in the middle of a stream.
        for (int c = 0; c < 3; c++) begin
            dbv = 1'($urandom_range(0, 1));
            drive_chk(1'b1, rand_fp(dbv), dbv, 1'b1, 4'(c + 7), 1'b1, 1'b0);
            commit();
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_outputs", snap(), 0);
        sb.delete();
        stalled_prev = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dir_op("post_rst", 64'h3FF0_0000_0000_0000, 1'b1, 1'b0, 1'b0, 11'h3FF,
               53'd1 << 52, 52'd0, 6'd0, 4'b0000);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
